fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the control unit. Holds the program counter,
//  turns the control unit's fetch pulse into an instruction-memory read, waits the memory
//  latency, then presents the word on ins with a one-cycle en_ram_out strobe.
//  Also applies the control unit's pc_ctrl / en_pc_pulse / offset_addr commands to the PC.
// PARAMETERS
//  DWIDTH  16  instruction word width
//  AWIDTH  8   PC / memory address width (>= 8)
//  RD_LAT  1   instruction-memory read latency in cycles, legal range 1..7
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  en           in   1       run enable; 0 = new fetch requests ignored
//  en_fetch     in   1       fetch request pulse (control unit en_ram_in)
//  en_pc_pulse  in   1       apply pc_ctrl at this edge
//  pc_ctrl      in   2       00 hold, 01 pc+1, 10 pc<=offset_addr, 11 pc<=pc+sext(offset_addr)
//  offset_addr  in   8       jump target / signed relative offset
//  mem_rdata    in   DWIDTH  instruction memory read data
//  mem_addr     out  AWIDTH  instruction memory address (registered)
//  mem_rd       out  1       memory read strobe, one cycle per fetch
//  ins          out  DWIDTH  fetched instruction (to control unit ins)
//  en_ram_out   out  1       one-cycle strobe: ins newly valid
//  pc           out  AWIDTH  current program counter
//  busy         out  1       1 while a fetch is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: pc=0, mem_addr=0, mem_rd=0, ins=0, en_ram_out=0, busy=0, state=IDLE, cnt=0.
//    rst mid-fetch aborts the read; no en_ram_out is produced for it.
//  - FSM IDLE -> READ -> IDLE (busy = state==READ). Counter cnt is 3 bits.
//  - IDLE, en & en_fetch sampled high at edge ending cycle T: mem_addr<=pc (pre-update value),
//    mem_rd<=1, cnt<=0, state<=READ. mem_addr/mem_rd valid in cycle T+1.
//  - READ: mem_rd<=0 after the first cycle; cnt increments each cycle; mem_rdata is valid
//    in the cycle where cnt==RD_LAT (cycle T+1+RD_LAT); at that edge ins<=mem_rdata,
//    en_ram_out<=1, state<=IDLE. en_ram_out high exactly cycle T+2+RD_LAT, 0 next cycle.
//  - Request-to-strobe latency RD_LAT+2 cycles; back-to-back fetch may be accepted in the
//    cycle en_ram_out is high (state already IDLE).
//  - en_fetch while busy: ignored, no queueing. en low does not abort an in-flight read.
//  - ins holds its value between fetches; mem_addr holds last fetched address.
//  - PC update on any edge with en_pc_pulse=1, independent of state and en:
//    01: pc+1; 10: {zeros, offset_addr}; 11: pc + sign-extended offset_addr.
//    All arithmetic modulo 2^AWIDTH (0xFF+1 -> 0x00 for AWIDTH=8; 0x00 + 0xFF -> 0xFF).
//  - en_fetch and en_pc_pulse on same edge: fetch uses old pc, pc updates at that edge.
// CONFIGURATION
//  - FETCH_AUTO_INC_EN defined: pc<=pc+1 at the edge that captures ins (en_ram_out rises),
//    unless en_pc_pulse is high at that same edge, in which case pc_ctrl wins alone.
//  - Not defined: pc changes only via en_pc_pulse; capture edge leaves pc untouched.
// TESTING
//  1 rst=1 for 2 cycles mid-fetch -> all outputs 0, no en_ram_out afterwards, pc=0.
//  2 RD_LAT=1, pc=0x05, mem[5]=0x1A3C, pulse en_fetch -> mem_rd 1 cycle with mem_addr=0x05,
//    en_ram_out exactly 3 cycles after request, ins=0x1A3C.
//  3 en_pc_pulse with pc_ctrl=10 offset 0x40 -> pc=0x40; then 11 offset 0xFE -> pc=0x3E;
//    pc=0xFF with 01 -> pc=0x00.
//  4 en_fetch again 1 cycle after accepted request (busy=1) -> ignored, one mem_rd and one
//    en_ram_out only; en=0 with en_fetch -> no mem_rd.
//  5 en_fetch + en_pc_pulse(01) same edge, pc=0x10 -> mem_addr=0x10, pc=0x11.
//  6 FETCH_AUTO_INC_EN, RD_LAT=3, pc=0x20: fetch -> en_ram_out after 5 cycles, pc=0x21;
//    repeat with en_pc_pulse(10,0x80) at capture edge -> pc=0x80.

Source files
------------

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage feeding the control unit. Owns the
//             program counter, converts a fetch pulse into a single
//             instruction-memory read, waits RD_LAT cycles for the data,
//             then presents the word on ins with a one-cycle en_ram_out
//             strobe. Also applies pc_ctrl commands to the PC.
//  Build option:
//             FETCH_AUTO_INC_EN - when defined, pc advances by one at the
//             edge that captures ins (an en_pc_pulse on that same edge
//             takes precedence and is applied alone).
//  Ports    :
//    clk          in   1       rising-edge clock
//    rst          in   1       synchronous reset, active-high
//    en           in   1       run enable; gates acceptance of new fetches
//    en_fetch     in   1       fetch request pulse
//    en_pc_pulse  in   1       apply pc_ctrl at this edge
//    pc_ctrl      in   2       00 hold, 01 pc+1, 10 load, 11 relative add
//    offset_addr  in   8       jump target / signed relative offset
//    mem_rdata    in   DWIDTH  instruction memory read data
//    mem_addr     out  AWIDTH  instruction memory address (registered)
//    mem_rd       out  1       one-cycle read strobe per fetch
//    ins          out  DWIDTH  last fetched instruction
//    en_ram_out   out  1       one-cycle strobe: ins newly valid
//    pc           out  AWIDTH  program counter
//    busy         out  1       high while a fetch is in flight
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1   // legal range 1..7 (cnt is 3 bits)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              en_fetch,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic [7:0]        offset_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DWIDTH-1:0] ins,
  output logic              en_ram_out,
  output logic [AWIDTH-1:0] pc,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [2:0]        LAT    = 3'(RD_LAT);
  localparam logic [AWIDTH-1:0] PC_ONE = AWIDTH'(1);

  state_t            state;
  logic [2:0]        cnt;
  logic              capture;
  logic [AWIDTH-1:0] offset_zext;
  logic [AWIDTH-1:0] offset_sext;
  logic [AWIDTH-1:0] pc_next;

  // Memory data is valid in the READ cycle where cnt reaches RD_LAT.
  assign capture     = (state == READ) && (cnt == LAT);
  assign offset_zext = AWIDTH'(offset_addr);
  assign offset_sext = AWIDTH'($signed(offset_addr));
  assign busy        = (state == READ);

  // PC commands act on any edge regardless of fetch state or en.
  always_comb begin
    pc_next = pc;
    if (en_pc_pulse) begin
      case (pc_ctrl)
        2'b01:   pc_next = pc + PC_ONE;
        2'b10:   pc_next = offset_zext;
        2'b11:   pc_next = pc + offset_sext;
        default: pc_next = pc;
      endcase
    end
`ifdef FETCH_AUTO_INC_EN
    else if (capture) begin
      pc_next = pc + PC_ONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      pc         <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      ins        <= '0;
      en_ram_out <= 1'b0;
    end else begin
      pc         <= pc_next;
      en_ram_out <= 1'b0;
      case (state)
        IDLE: begin
          mem_rd <= 1'b0;
          if (en && en_fetch) begin
            // Fetch uses the PC value before any same-edge update.
            mem_addr <= pc;
            mem_rd   <= 1'b1;
            cnt      <= 3'd0;
            state    <= READ;
          end
        end
        READ: begin
          mem_rd <= 1'b0;
          cnt    <= cnt + 3'd1;
          if (capture) begin
            ins        <= mem_rdata;
            en_ram_out <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Scoreboard bench for fetch_unit. Two instances (RD_LAT=1 and
//             RD_LAT=3) share one stimulus stream; each has its own pipelined
//             memory model that returns 16'hDEAD except in the cycle a read
//             result is due. Expected reads and strobes are queued when a
//             request is issued and popped by a negedge monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, en, en_fetch, en_pc_pulse;
  logic [1:0]  pc_ctrl;
  logic [7:0]  offset_addr;

  logic [15:0] mem_rdata1, mem_rdata3;
  logic [7:0]  mem_addr1, mem_addr3, pc1, pc3;
  logic        mem_rd1, mem_rd3, en_ram_out1, en_ram_out3, busy1, busy3;
  logic [15:0] ins1, ins3;

  always #5 clk = ~clk;

  fetch_unit #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .en_fetch(en_fetch),
    .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .ins(ins1), .en_ram_out(en_ram_out1), .pc(pc1), .busy(busy1)
  );

  fetch_unit #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .en_fetch(en_fetch),
    .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .mem_rdata(mem_rdata3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
    .ins(ins3), .en_ram_out(en_ram_out3), .pc(pc3), .busy(busy3)
  );

`ifdef FETCH_AUTO_INC_EN
  localparam logic [7:0] AUTO = 8'd1;
`else
  localparam logic [7:0] AUTO = 8'd0;
`endif

  // Memory models: data only appears RD_LAT cycles after the read strobe.
  logic [15:0] mem [256];
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    mem_rdata1 <= mem_rd1 ? mem[mem_addr1] : 16'hDEAD;
    p3[0]      <= mem_rd3 ? mem[mem_addr3] : 16'hDEAD;
    p3[1]      <= p3[0];
    p3[2]      <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t q_addr1[$], q_addr3[$], q_ins1[$], q_ins3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected strobe, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every read strobe and every en_ram_out strobe.
  exp_t e;
  always @(negedge clk) begin
    if (mem_rd1) begin
      if (q_addr1.size() == 0) unexpected("dut1 mem_rd");
      else begin
        e = q_addr1.pop_front();
        chk("dut1 mem_addr", {24'd0, mem_addr1}, {16'd0, e.d});
        chk("dut1 mem_rd cycle", cyc, e.c);
      end
    end
    if (mem_rd3) begin
      if (q_addr3.size() == 0) unexpected("dut3 mem_rd");
      else begin
        e = q_addr3.pop_front();
        chk("dut3 mem_addr", {24'd0, mem_addr3}, {16'd0, e.d});
        chk("dut3 mem_rd cycle", cyc, e.c);
      end
    end
    if (en_ram_out1) begin
      if (q_ins1.size() == 0) unexpected("dut1 en_ram_out");
      else begin
        e = q_ins1.pop_front();
        chk("dut1 ins", {16'd0, ins1}, {16'd0, e.d});
        chk("dut1 strobe cycle", cyc, e.c);
      end
    end
    if (en_ram_out3) begin
      if (q_ins3.size() == 0) unexpected("dut3 en_ram_out");
      else begin
        e = q_ins3.pop_front();
        chk("dut3 ins", {16'd0, ins3}, {16'd0, e.d});
        chk("dut3 strobe cycle", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [1:0] ctrl, input logic [7:0] off);
    en_pc_pulse = 1'b1;
    pc_ctrl     = ctrl;
    offset_addr = off;
    tick();
    en_pc_pulse = 1'b0;
    pc_ctrl     = 2'b00;
  endtask

  // Raise a request in the current cycle and queue what both DUTs owe.
  task automatic fetch_req(input logic [7:0] addr, input logic [15:0] d, input bit strobe);
    en       = 1'b1;
    en_fetch = 1'b1;
    q_addr1.push_back('{d: {8'd0, addr}, c: cyc + 1});
    q_addr3.push_back('{d: {8'd0, addr}, c: cyc + 1});
    if (strobe) begin
      q_ins1.push_back('{d: d, c: cyc + 3});
      q_ins3.push_back('{d: d, c: cyc + 5});
    end
  endtask

  function automatic int pending();
    return q_addr1.size() + q_addr3.size() + q_ins1.size() + q_ins3.size();
  endfunction

  task automatic wait_done();
    int n = 0;
    while (pending() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL wait_done: %0d items still pending, expected 0", pending());
    end
  endtask

  logic [7:0]  a;
  logic [15:0] d;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h05] = 16'h1A3C;
    mem[8'h07] = 16'h7777;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'h2020;
    mem[8'h21] = 16'h2121;
    mem[8'h33] = 16'h3333;

    rst = 1'b1; en = 1'b0; en_fetch = 1'b0; en_pc_pulse = 1'b0;
    pc_ctrl = 2'b00; offset_addr = 8'h00;
    repeat (3) tick();
    chk("reset pc", {24'd0, pc1}, 32'h0);
    chk("reset outputs", {13'd0, busy1, en_ram_out1, mem_rd1, ins1}, 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Reset in the middle of a fetch aborts it.
    set_pc(2'b10, 8'h33);
    chk("pc load 0x33", {24'd0, pc1}, 32'h33);
    fetch_req(8'h33, 16'h0000, 1'b0);
    tick();
    en_fetch = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("mid-fetch reset dut1", {pc1, mem_addr1, 5'd0, busy1, en_ram_out1, mem_rd1, ins1[7:0]}, 32'h0);
    chk("mid-fetch reset dut3", {pc3, mem_addr3, 5'd0, busy3, en_ram_out3, mem_rd3, ins3[7:0]}, 32'h0);
    chk("mid-fetch reset ins", {ins3, ins1}, 32'h0);
    repeat (6) tick();

    // Basic fetch from 0x05.
    set_pc(2'b10, 8'h05);
    fetch_req(8'h05, 16'h1A3C, 1'b1);
    tick();
    en_fetch = 1'b0;
    wait_done();
    chk("pc after fetch 0x05", {pc3, pc1}, {16'd0, 8'h05 + AUTO, 8'h05 + AUTO});
    chk("ins/mem_addr hold", {8'd0, mem_addr1, ins1}, 32'h00051A3C);

    // PC arithmetic.
    set_pc(2'b10, 8'h40);
    chk("pc load 0x40", {24'd0, pc1}, 32'h40);
    set_pc(2'b11, 8'hFE);
    chk("pc rel -2", {pc3, pc1}, 32'h3E3E);
    set_pc(2'b10, 8'hFF);
    set_pc(2'b01, 8'h00);
    chk("pc wrap 0xFF+1", {pc3, pc1}, 32'h0000);
    set_pc(2'b11, 8'hFF);
    chk("pc 0x00+0xFF", {24'd0, pc1}, 32'hFF);
    set_pc(2'b00, 8'h12);
    chk("pc hold", {24'd0, pc1}, 32'hFF);

    // en_fetch held while busy is ignored; en=0 blocks a request.
    set_pc(2'b10, 8'h07);
    fetch_req(8'h07, 16'h7777, 1'b1);
    tick();
    chk("busy after accept", {30'd0, busy3, busy1}, 32'h3);
    tick();
    en_fetch = 1'b0;
    wait_done();
    en = 1'b0;
    en_fetch = 1'b1;
    tick();
    chk("en=0 blocks fetch", {30'd0, busy3, busy1}, 32'h0);
    en_fetch = 1'b0;
    en = 1'b1;
    repeat (6) tick();

    // Fetch and pc+1 on the same edge.
    set_pc(2'b10, 8'h10);
    fetch_req(8'h10, 16'hBEEF, 1'b1);
    en_pc_pulse = 1'b1;
    pc_ctrl = 2'b01;
    tick();
    en_fetch = 1'b0;
    en_pc_pulse = 1'b0;
    pc_ctrl = 2'b00;
    chk("same-edge pc+1", {pc3, pc1}, 32'h1111);
    wait_done();
    chk("pc after same-edge fetch", {pc3, pc1}, {16'd0, 8'h11 + AUTO, 8'h11 + AUTO});

    // Capture-edge behaviour of the PC.
    set_pc(2'b10, 8'h20);
    fetch_req(8'h20, 16'h2020, 1'b1);
    tick();
    en_fetch = 1'b0;
    wait_done();
    chk("pc after fetch 0x20", {pc3, pc1}, {16'd0, 8'h20 + AUTO, 8'h20 + AUTO});
    a = 8'h20 + AUTO;
    d = (a == 8'h21) ? 16'h2121 : 16'h2020;
    fetch_req(a, d, 1'b1);
    tick();
    en_fetch = 1'b0;
    repeat (3) tick();
    set_pc(2'b10, 8'h80);   // lands on the RD_LAT=3 capture edge
    wait_done();
    chk("pc load wins at capture", {pc3, pc1}, 32'h8080);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
